ram_line_buffer_pool: RTL

//  Multi-line, multi-channel RAM-based line buffer feeding the pooling window logic.

---
 rtl/ram_line_buffer_pool_pkg.sv | 17 +
 rtl/ram_line_buffer_pool_sdp_ram.sv | 59 +++++
 rtl/ram_line_buffer_pool.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ram_line_buffer_pool_pkg.sv
// Shared definitions for the pooling line buffer: target device select, tap limits
// and the tap/slot bit-position helper used to address packed tap columns.
package ram_line_buffer_pool_pkg;

    localparam int DEVICE_SIM    = 0;
    localparam int DEVICE_VENDOR = 1;
    localparam int DEVICE        = DEVICE_SIM;

    localparam int MAX_TAPS = 8;
    localparam int ROWS_W   = $clog2(MAX_TAPS);

    // LSB position of tap (or RAM slot) 'tap' inside a packed column of pix_w-bit pixels
    function automatic int tap_lsb(input int tap, input int pix_w);
        return tap * pix_w;
    endfunction

endpackage

// File: rtl/ram_line_buffer_pool_sdp_ram.sv
// Simple dual-port RAM with a one-cycle registered read, one clock.
// The vendor flavour registers the read address, as inferred block RAMs do.
module ram_line_buffer_pool_sdp_ram
    import ram_line_buffer_pool_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int DEVICE_SEL = DEVICE
) (
    input  logic              system_clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    logic [WORD_W-1:0] mem_r [2**ADDR_W];

    // Write port; contents are never reset
    always_ff @(posedge system_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    generate
        if (DEVICE_SEL == DEVICE_SIM) begin : g_sim
            logic [WORD_W-1:0] rd_data_r;

            // Registered read data
            always_ff @(posedge system_clk) begin
                if (rst) begin
                    rd_data_r <= '0;
                end else if (rd_en) begin
                    rd_data_r <= mem_r[rd_addr];
                end
            end

            assign rd_data = rd_data_r;
        end else begin : g_vendor
            logic [ADDR_W-1:0] rd_addr_r;

            // Registered read address, data read through from the array
            always_ff @(posedge system_clk) begin
                if (rst) begin
                    rd_addr_r <= '0;
                end else if (rd_en) begin
                    rd_addr_r <= rd_addr;
                end
            end

            assign rd_data = mem_r[rd_addr_r];
        end
    endgenerate

endmodule

// File: rtl/ram_line_buffer_pool.sv
// RAM-based line buffer: each accepted pixel yields a vertical tap column (current
// pixel plus TAPS-1 rows above) one cycle later, with per-tap fill flags.
module ram_line_buffer_pool
    import ram_line_buffer_pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CH     = 1,
    parameter int TAPS   = 2,
    parameter int ADDR_W = 8,
    parameter int COL_W  = 10
) (
    input  logic                     system_clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [COL_W-1:0]         col_size,
    input  logic                     in_valid,
    input  logic [CH*DATA_W-1:0]     in_data,
    output logic                     out_valid,
    output logic [TAPS*CH*DATA_W-1:0] out_data,
    output logic [TAPS-1:0]          out_tap_vld,
    output logic [COL_W-1:0]         out_col,
    output logic                     out_last_col,
    output logic                     cfg_err
);

    localparam int PIX_W  = CH * DATA_W;
    localparam int WORD_W = (TAPS - 1) * PIX_W;
    localparam logic [COL_W:0] MAX_COLS = (COL_W + 1)'(2**ADDR_W);

    logic                flush_s;
    logic                size_bad_s;
    logic                accept_s;
    logic                last_s;
    logic                wr_en_s;
    logic [TAPS-1:0]     tap_vld_s;
    logic [WORD_W-1:0]   rd_word_s;
    logic [TAPS*PIX_W-1:0] col_word_s;

    logic [COL_W-1:0]    col_r;
    logic [ROWS_W-1:0]   rows_done_r;
    logic                cfg_err_r;
    logic                valid_d_r;
    logic [PIX_W-1:0]    data_d_r;
    logic [COL_W-1:0]    col_d_r;
    logic                last_d_r;
    logic [TAPS-1:0]     tap_vld_d_r;

    assign flush_s    = rst | clear;
    assign size_bad_s = ({1'b0, col_size} < (COL_W + 1)'(2)) | ({1'b0, col_size} > MAX_COLS);
    assign accept_s   = in_valid & ~cfg_err_r & ~size_bad_s & ~flush_s;
    assign last_s     = (col_r == (col_size - COL_W'(1)));
    // A flush in the stage-1 cycle kills that pixel's write-back
    assign wr_en_s    = valid_d_r & ~flush_s;

    // Taps at or below the number of completed rows hold real data
    always_comb begin
        tap_vld_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (ROWS_W'(k) <= rows_done_r) begin
                tap_vld_s[k] = 1'b1;
            end else begin
                tap_vld_s[k] = 1'b0;
            end
        end
    end

    // Stage 0 capture, column/row counters and sticky configuration error
    always_ff @(posedge system_clk) begin
        if (flush_s) begin
            col_r       <= '0;
            rows_done_r <= '0;
            cfg_err_r   <= 1'b0;
            valid_d_r   <= 1'b0;
            data_d_r    <= '0;
            col_d_r     <= '0;
            last_d_r    <= 1'b0;
            tap_vld_d_r <= '0;
        end else begin
            if (in_valid && size_bad_s) begin
                cfg_err_r <= 1'b1;
            end
            valid_d_r <= accept_s;
            if (accept_s) begin
                data_d_r    <= in_data;
                col_d_r     <= col_r;
                last_d_r    <= last_s;
                tap_vld_d_r <= tap_vld_s;
                if (last_s) begin
                    col_r <= '0;
                    if (rows_done_r < ROWS_W'(TAPS - 1)) begin
                        rows_done_r <= rows_done_r + ROWS_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    ram_line_buffer_pool_sdp_ram #(
        .WORD_W     (WORD_W),
        .ADDR_W     (ADDR_W),
        .DEVICE_SEL (DEVICE)
    ) u_ram (
        .system_clk (system_clk),
        .rst        (rst),
        .rd_en      (accept_s),
        .rd_addr    (col_r[ADDR_W-1:0]),
        .rd_data    (rd_word_s),
        .wr_en      (wr_en_s),
        .wr_addr    (col_d_r[ADDR_W-1:0]),
        .wr_data    (col_word_s[WORD_W-1:0])
    );

    // Full column is {oldest .. line1, current}; dropping the oldest ages every slot by one row
    assign col_word_s = {rd_word_s, data_d_r};

    // Output column, zero while no pixel is presented
    always_comb begin
        if (valid_d_r) begin
            out_data = col_word_s;
        end else begin
            out_data = '0;
        end
    end

    assign out_valid    = valid_d_r;
    assign out_tap_vld  = tap_vld_d_r;
    assign out_col      = col_d_r;
    assign out_last_col = last_d_r;
    assign cfg_err      = cfg_err_r;

endmodule
